pc_next: RTL and testbench

PC_NEXT -- requirements
Module: pc_next

---
 rtl/pc_next.sv | 94 +++++++++
 tb/tb_pc_next.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next.sv
// Program-counter next-address unit: sequential fetch, jump redirect, stall hold with pending redirect.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of forcing word alignment.
module pc_next #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jumpctrl,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        fetch_valid
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        trap
`endif
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [1:0] TRAP = 2'd3;
`endif

  logic [1:0]  state, state_nx;
  logic [31:0] pending, pending_nx;
  logic [31:0] pc_nx;
  logic        flush_nx;
  logic [31:0] redirect_target;

  assign pc_plus4 = pc + 32'd4;

  // A redirect issued in the same cycle that a stall drops takes priority over the stored one.
  assign redirect_target = jumpctrl ? jump_target : pending;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pending_nx = pending;
    flush_nx   = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN, PEND: begin
        if (stall) begin
          if (jumpctrl) begin
            pending_nx = jump_target;
            state_nx   = PEND;
          end
        end else if (jumpctrl || (state == PEND)) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (redirect_target[1:0] != 2'b00) begin
            state_nx = TRAP;
          end else begin
            pc_nx    = redirect_target;
            flush_nx = 1'b1;
            state_nx = RUN;
          end
`else
          pc_nx    = redirect_target & ~32'h3;
          flush_nx = 1'b1;
          state_nx = RUN;
`endif
        end else begin
          pc_nx = pc_plus4;
        end
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_VECTOR;
      pending <= 32'h0;
      flush   <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      pending <= pending_nx;
      flush   <= flush_nx;
    end
  end

  // Status flags come straight from the registered state, so reset clears them immediately.
  assign fetch_valid = (state == RUN) || (state == PEND);
`ifdef PC_MISALIGN_TRAP_EN
  assign trap = (state == TRAP);
`endif

endmodule

// File: tb/tb_pc_next.sv
// Self-checking bench for pc_next: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a rule-level reference model.
module tb_pc_next;

  logic        clk;
  logic        rst_n;
  logic        jumpctrl;
  logic [31:0] jump_target;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        fetch_valid;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
`endif

  int compared;
  int mismatched;

  pc_next #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jumpctrl    (jumpctrl),
    .jump_target (jump_target),
    .stall       (stall),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .flush       (flush),
    .fetch_valid (fetch_valid)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .trap        (trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jc;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[18];

  // Reference model: tracks what the fetch unit should be doing, in terms of the rules only.
  logic [31:0] m_pc;
  logic        m_booted;
  logic        m_pend_valid;
  logic [31:0] m_pend;
  logic        m_flush;
  logic        m_trapped;

  task automatic modelReset();
    m_pc = 32'h0;
    m_booted = 1'b0;
    m_pend_valid = 1'b0;
    m_pend = 32'h0;
    m_flush = 1'b0;
    m_trapped = 1'b0;
  endtask

  task automatic modelEdge(input logic s, input logic jc, input logic [31:0] tgt);
    logic [31:0] t;
    m_flush = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (!m_trapped) begin
      if (s) begin
        if (jc) begin
          m_pend_valid = 1'b1;
          m_pend = tgt;
        end
      end else if (jc || m_pend_valid) begin
        t = jc ? tgt : m_pend;
        m_pend_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (t % 4 != 0) m_trapped = 1'b1;
        else begin
          m_pc = t;
          m_flush = 1'b1;
        end
`else
        m_pc = t - (t % 4);
        m_flush = 1'b1;
`endif
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic jc, input logic [31:0] tgt);
    stall = s;
    jumpctrl = jc;
    jump_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " pc"}, pc, m_pc);
    checkOutput({tag, " pc_plus4"}, pc_plus4, m_pc + 32'd4);
    checkOutput({tag, " flush"}, {31'b0, flush}, {31'b0, m_flush});
    checkOutput({tag, " fetch_valid"}, {31'b0, fetch_valid}, {31'b0, m_booted & ~m_trapped});
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput({tag, " trap"}, {31'b0, trap}, {31'b0, m_trapped});
`endif
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    stall = 1'b1;
    jumpctrl = 1'b1;
    jump_target = 32'h0000_0700;
    #1;
    checkOutput({tag, " async pc"}, pc, 32'h0);
    checkOutput({tag, " async flush"}, {31'b0, flush}, 32'h0);
    checkOutput({tag, " async fetch_valid"}, {31'b0, fetch_valid}, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput({tag, " async trap"}, {31'b0, trap}, 32'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    jumpctrl = 1'b0;
    jump_target = 32'h0;

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0104, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0104, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0080, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0084, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'hDEAD_0000, 32'h0000_0008, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0024, 1'b0};

    #12;
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset fetch_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("reset flush", {31'b0, flush}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].jc, vecs[i].tgt);
      checkOutput($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      checkOutput($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
      checkOutput($sformatf("vec%0d fetch_valid", i), {31'b0, fetch_valid}, 32'h1);
    end

    // Misaligned redirect from pc 0x24
    applyStimulus(1'b0, 1'b1, 32'h0000_0102);
`ifdef PC_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("trap%0d pc", i), pc, 32'h0000_0024);
      checkOutput($sformatf("trap%0d trap", i), {31'b0, trap}, 32'h1);
      checkOutput($sformatf("trap%0d fetch_valid", i), {31'b0, fetch_valid}, 32'h0);
      checkOutput($sformatf("trap%0d flush", i), {31'b0, flush}, 32'h0);
      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 32'h0000_0500);
    end
`else
    checkOutput("misalign pc", pc, 32'h0000_0100);
    checkOutput("misalign flush", {31'b0, flush}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("misalign next pc", pc, 32'h0000_0104);
`endif

    doReset("rst1");
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pend pre pc", pc, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0300);
    checkOutput("pend hold pc", pc, 32'h0);
    checkOutput("pend hold fetch_valid", {31'b0, fetch_valid}, 32'h1);
    #2;
    doReset("rst_pend");
    applyStimulus(1'b1, 1'b1, 32'h0000_0700);
    checkOutput("boot pc", pc, 32'h0);
    checkOutput("boot flush", {31'b0, flush}, 32'h0);
    checkOutput("boot fetch_valid", {31'b0, fetch_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("after pend reset pc", pc, 32'h4);
    checkOutput("after pend reset flush", {31'b0, flush}, 32'h0);

    doReset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      logic        s;
      logic        jc;
      logic [31:0] tgt;
      s = ($urandom_range(0, 2) == 0);
      jc = ($urandom_range(0, 3) == 0);
      tgt = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
      if (i < 380) tgt = tgt & ~32'h3;
`endif
      applyStimulus(s, jc, tgt);
      modelEdge(s, jc, tgt);
      checkModel($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
